assign_perm_sequencer: RTL and testbench



---
 rtl/assign_pkg.sv | 32 +++
 rtl/perm_pivot_find.sv | 64 ++++++
 rtl/assign_perm_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_assign_perm_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assign_pkg.sv
// -----------------------------------------------------------------------------
// assign_pkg
//   Shared definitions for the 8-worker / 8-job assignment search: problem
//   size, index and cost widths, the sequencer state encoding and the
//   arrangement type used by CalCost and the permutation sequencer.
// -----------------------------------------------------------------------------
package assign_pkg;

  // Workers / jobs. The arrangement index width fixes the upper bound at 8.
  localparam int N      = 8;
  localparam int IDX_W  = 3;
  // Width of one permutation's total cost.
  localparam int COST_W = 10;
  // Width of the saturating count of permutations that hit the minimum.
  localparam int CNT_W  = 4;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    LAUNCH,
    WAIT,
    UPDATE,
    FIND,
    SWAP,
    REV,
    FINISH
  } state_t;

  // arrange[k] = job assigned to worker k.
  typedef logic [IDX_W-1:0] arrange_t [0:N-1];

endpackage

// File: rtl/perm_pivot_find.sv
// -----------------------------------------------------------------------------
// perm_pivot_find
//   Purely combinational pivot search for lexicographic next-permutation.
//
//   Ports:
//     arrange    in   current arrangement, arrange[k] = job of worker k
//     has_pivot  out  1 when some p exists with arrange[p] < arrange[p+1]
//     p          out  largest such p (0 when has_pivot = 0)
//     s          out  largest index > p with arrange[s] > arrange[p]
// -----------------------------------------------------------------------------
module perm_pivot_find #(
  parameter int N = assign_pkg::N
) (
  input  logic [assign_pkg::IDX_W-1:0] arrange [0:N-1],
  output logic                         has_pivot,
  output logic [assign_pkg::IDX_W-1:0] p,
  output logic [assign_pkg::IDX_W-1:0] s
);
  import assign_pkg::*;

  logic [N-2:0]     asc;    // asc[k]: arrange[k] < arrange[k+1]
  logic [N-1:0]     gt;     // gt[k]: k lies right of p and exceeds arrange[p]
  logic [IDX_W-1:0] arr_p;

  genvar gi;

  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_asc
      assign asc[gi] = arrange[gi] < arrange[gi+1];
    end
  endgenerate

  // Highest ascending step wins: later loop iterations overwrite earlier ones.
  always_comb begin
    has_pivot = 1'b0;
    p         = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (asc[k]) begin
        has_pivot = 1'b1;
        p         = IDX_W'(k);
      end
    end
  end

  assign arr_p = arrange[p];

  generate
    for (gi = 0; gi < N; gi++) begin : g_gt
      assign gt[gi] = (IDX_W'(gi) > p) && (arrange[gi] > arr_p);
    end
  endgenerate

  // The suffix right of p is descending, so the rightmost larger element is
  // the smallest value exceeding arrange[p].
  always_comb begin
    s = '0;
    for (int k = 0; k < N; k++) begin
      if (gt[k]) begin
        s = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/assign_perm_sequencer.sv
// -----------------------------------------------------------------------------
// assign_perm_sequencer
//   Walks every permutation of the N jobs in lexicographic order, launches one
//   CalCost evaluation per permutation and keeps the global minimum cost and
//   the (saturating) number of permutations reaching it.
//
//   Ports:
//     CLK         in   clock, all state on the rising edge
//     RST         in   asynchronous active-low reset
//     start       in   begin a full search (only looked at in IDLE)
//     cal_start   out  one-cycle launch pulse to CalCost
//     cal_done    in   CalCost completion pulse (only looked at in WAIT)
//     cal_cost    in   total cost of the launched permutation
//     arrange     out  job for each worker, stable from cal_start to cal_done
//     busy        out  high whenever the sequencer is not in IDLE
//     MinCost     out  global minimum cost
//     MatchCount  out  permutations equal to MinCost, saturating
//     Valid       out  one-cycle pulse when the results are final
// -----------------------------------------------------------------------------
module assign_perm_sequencer #(
  parameter int N      = assign_pkg::N,
  parameter int COST_W = assign_pkg::COST_W,
  parameter int CNT_W  = assign_pkg::CNT_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  output logic                         cal_start,
  input  logic                         cal_done,
  input  logic [COST_W-1:0]            cal_cost,
  output logic [assign_pkg::IDX_W-1:0] arrange [0:N-1],
  output logic                         busy,
  output logic [COST_W-1:0]            MinCost,
  output logic [CNT_W-1:0]             MatchCount,
  output logic                         Valid
);
  import assign_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] arrange_q [0:N-1];
  logic [IDX_W-1:0] arrange_d [0:N-1];
  logic [IDX_W-1:0] p_q, p_d;
  logic [IDX_W-1:0] s_q, s_d;
  logic [IDX_W-1:0] lo_q, lo_d;
  logic [IDX_W-1:0] hi_q, hi_d;
  logic [COST_W-1:0] cost_q, cost_d;
  logic [COST_W-1:0] min_cost_q, min_cost_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

  logic             piv_has;
  logic [IDX_W-1:0] piv_p;
  logic [IDX_W-1:0] piv_s;

  genvar gi;

  perm_pivot_find #(
    .N (N)
  ) u_pivot (
    .arrange   (arrange_q),
    .has_pivot (piv_has),
    .p         (piv_p),
    .s         (piv_s)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    arrange_d   = arrange_q;
    p_d         = p_q;
    s_d         = s_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cost_d      = cost_q;
    min_cost_d  = min_cost_q;
    match_cnt_d = match_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
        end
      end

      INIT: begin
        for (int k = 0; k < N; k++) begin
          arrange_d[k] = IDX_W'(k);
        end
        min_cost_d  = '1;
        match_cnt_d = '0;
        state_d     = LAUNCH;
      end

      LAUNCH: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (cal_done) begin
          cost_d  = cal_cost;
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        if (cost_q < min_cost_q) begin
          min_cost_d  = cost_q;
          match_cnt_d = CNT_W'(1);
        end else if (cost_q == min_cost_q) begin
          if (match_cnt_q != {CNT_W{1'b1}}) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
          end
        end
        state_d = FIND;
      end

      FIND: begin
        if (piv_has) begin
          p_d     = piv_p;
          s_d     = piv_s;
          state_d = SWAP;
        end else begin
          state_d = FINISH;
        end
      end

      SWAP: begin
        arrange_d[p_q] = arrange_q[s_q];
        arrange_d[s_q] = arrange_q[p_q];
        lo_d           = p_q + IDX_W'(1);
        hi_d           = LAST_IDX;
        // A one-element suffix needs no reversal, so skip REV entirely.
        if ((p_q + IDX_W'(1)) < LAST_IDX) begin
          state_d = REV;
        end else begin
          state_d = LAUNCH;
        end
      end

      REV: begin
        // Only entered with lo < hi. Each visit swaps one pair; leave as soon
        // as the narrowed window would no longer hold a pair, so the number
        // of REV cycles equals the number of swaps.
        if (lo_q < hi_q) begin
          arrange_d[lo_q] = arrange_q[hi_q];
          arrange_d[hi_q] = arrange_q[lo_q];
        end
        lo_d = lo_q + IDX_W'(1);
        hi_d = hi_q - IDX_W'(1);
        if ((lo_q + IDX_W'(1)) < (hi_q - IDX_W'(1))) begin
          state_d = REV;
        end else begin
          state_d = LAUNCH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      for (int k = 0; k < N; k++) begin
        arrange_q[k] <= IDX_W'(k);
      end
      p_q         <= '0;
      s_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cost_q      <= '0;
      min_cost_q  <= '1;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      arrange_q   <= arrange_d;
      p_q         <= p_d;
      s_q         <= s_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cost_q      <= cost_d;
      min_cost_q  <= min_cost_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register so an asynchronous reset clears
  // them immediately.
  // ---------------------------------------------------------------------------
  assign cal_start  = (state_q == LAUNCH);
  assign Valid      = (state_q == FINISH);
  assign busy       = (state_q != IDLE);
  assign MinCost    = min_cost_q;
  assign MatchCount = match_cnt_q;

  generate
    for (gi = 0; gi < N; gi++) begin : g_arr_out
      assign arrange[gi] = arrange_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_assign_perm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_assign_perm_sequencer
//   Drives assign_perm_sequencer with a CalCost stand-in and compares every
//   launched arrangement and every final result against a reference built
//   from factorial-number-system permutation indexing. The design is built
//   with 6 jobs so each full search stays at 720 permutations.
// -----------------------------------------------------------------------------
module tb_assign_perm_sequencer;

  localparam int N      = 6;
  localparam int COST_W = 10;
  localparam int CNT_W  = 4;
  localparam int AW     = 3 * N;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              start = 1'b0;
  logic              cal_done = 1'b0;
  logic [COST_W-1:0] cal_cost = '0;
  logic              cal_start;
  logic [2:0]        arrange [0:N-1];
  logic              busy;
  logic [COST_W-1:0] MinCost;
  logic [CNT_W-1:0]  MatchCount;
  logic              Valid;

  assign_perm_sequencer #(
    .N      (N),
    .COST_W (COST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .cal_start  (cal_start),
    .cal_done   (cal_done),
    .cal_cost   (cal_cost),
    .arrange    (arrange),
    .busy       (busy),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Cost stand-in: 0 = identity scores 0 else 50, 1 = constant 37,
  // 2 = sum of a random per-worker/per-job matrix.
  int mode = 0;
  int dly_lo = 0;
  int dly_hi = 0;
  bit inject = 1'b0;
  int mat [0:7][0:7];

  logic [AW-1:0]           exp_arr_q [$];
  logic [COST_W+CNT_W-1:0] exp_res_q [$];
  int launches = 0;
  int valid_cnt = 0;

  // Stand-in state
  bit            pend = 1'b0;
  bit            moved = 1'b0;
  bit            relaunch = 1'b0;
  int            wait_cnt = 0;
  logic [AW-1:0] cap = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fact(input int n);
    int r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  function automatic logic [AW-1:0] ident();
    logic [AW-1:0] w = '0;
    for (int k = 0; k < N; k++) w[3*k +: 3] = 3'(k);
    return w;
  endfunction

  function automatic logic [AW-1:0] pack_arr();
    logic [AW-1:0] w = '0;
    for (int k = 0; k < N; k++) w[3*k +: 3] = arrange[k];
    return w;
  endfunction

  // idx-th permutation in lexicographic order via its factoradic digits.
  function automatic logic [AW-1:0] perm_of(input int idx);
    int avail [$];
    int rem;
    int d;
    int f;
    logic [AW-1:0] w = '0;
    rem = idx;
    for (int k = 0; k < N; k++) avail.push_back(k);
    for (int k = 0; k < N; k++) begin
      f   = fact(N - 1 - k);
      d   = rem / f;
      rem = rem % f;
      w[3*k +: 3] = 3'(avail[d]);
      avail.delete(d);
    end
    return w;
  endfunction

  function automatic int cost_of(input logic [AW-1:0] w);
    int c = 0;
    case (mode)
      0: c = (w == ident()) ? 0 : 50;
      1: c = 37;
      default: begin
        for (int k = 0; k < N; k++) c += mat[k][int'(w[3*k +: 3])];
      end
    endcase
    return c;
  endfunction

  task automatic prepare_expect(output int em, output int ec);
    int costs [$];
    logic [AW-1:0] w;
    em = (1 << COST_W) - 1;
    ec = 0;
    for (int i = 0; i < fact(N); i++) begin
      w = perm_of(i);
      exp_arr_q.push_back(w);
      costs.push_back(cost_of(w));
    end
    foreach (costs[i]) if (costs[i] < em) em = costs[i];
    foreach (costs[i]) if (costs[i] == em) ec++;
    if (ec > (1 << CNT_W) - 1) ec = (1 << CNT_W) - 1;
    exp_res_q.push_back({COST_W'(em), CNT_W'(ec)});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cal_start"}, 64'(cal_start), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_valid"}, 64'(Valid), 64'(0));
    check({tag, "_mincost"}, 64'(MinCost), 64'((1 << COST_W) - 1));
    check({tag, "_matchcount"}, 64'(MatchCount), 64'(0));
    check({tag, "_arrange"}, 64'(pack_arr()), 64'(ident()));
  endtask

  // CalCost stand-in: answers each launch after a random delay and watches
  // the arrangement while it is outstanding.
  initial begin
    forever begin
      @(negedge CLK);
      cal_done = 1'b0;
      if (!RST) begin
        pend = 1'b0;
      end else if (pend) begin
        if (pack_arr() != cap) moved = 1'b1;
        if (cal_start) relaunch = 1'b1;
        if (wait_cnt == 0) begin
          cal_cost = COST_W'(cost_of(cap));
          cal_done = 1'b1;
          pend     = 1'b0;
          check("arrange_stable_in_wait", 64'(moved), 64'(0));
          check("no_relaunch_in_wait", 64'(relaunch), 64'(0));
        end else begin
          wait_cnt--;
        end
      end else if (cal_start) begin
        cap      = pack_arr();
        pend     = 1'b1;
        moved    = 1'b0;
        relaunch = 1'b0;
        wait_cnt = int'($urandom_range(dly_hi, dly_lo));
      end else if (inject && ($urandom_range(0, 3) == 0)) begin
        // Stray completion while the sequencer is not waiting; poisoned cost.
        cal_cost = '0;
        cal_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [AW-1:0]           e;
    logic [COST_W+CNT_W-1:0] r;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        launches = 0;
      end else begin
        if (cal_start) begin
          if (exp_arr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_launch: arrange 0x%0h with nothing expected", pack_arr());
          end else begin
            e = exp_arr_q.pop_front();
            check("arrange_at_launch", 64'(pack_arr()), 64'(e));
          end
          launches++;
        end
        if (Valid) begin
          valid_cnt++;
          if (exp_res_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: MinCost %0d MatchCount %0d", MinCost, MatchCount);
          end else begin
            r = exp_res_q.pop_front();
            check("min_cost", 64'(MinCost), 64'(r[CNT_W +: COST_W]));
            check("match_count", 64'(MatchCount), 64'(r[CNT_W-1:0]));
            check("launch_count", 64'(launches), 64'(fact(N)));
            check("perms_left", 64'(exp_arr_q.size()), 64'(0));
          end
          launches = 0;
        end
      end
    end
  end

  task automatic run_search(input int m, input int dlo, input int dhi, input bit inj);
    int em;
    int ec;
    bit done = 1'b0;
    int budget;
    mode   = m;
    dly_lo = dlo;
    dly_hi = dhi;
    prepare_expect(em, ec);
    budget = fact(N) * (dhi + 12) + 100;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    inject = inj;
    check("busy_after_start", 64'(busy), 64'(1));
    check("no_launch_in_init", 64'(cal_start), 64'(0));
    @(negedge CLK);
    check("first_launch_timing", 64'(cal_start), 64'(1));
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (Valid) done = 1'b1;
      else if (inj && busy && ($urandom_range(0, 15) == 0)) start = 1'b1;
    end
    start  = 1'b0;
    inject = 1'b0;
    check("search_completes", 64'(done), 64'(1));
    if (!done) begin
      RST = 1'b0;
      @(negedge CLK);
      exp_arr_q.delete();
      exp_res_q.delete();
      RST = 1'b1;
    end else begin
      @(negedge CLK);
      check("valid_one_cycle", 64'(Valid), 64'(0));
      check("busy_after_valid", 64'(busy), 64'(0));
      repeat (3) @(negedge CLK);
      check("mincost_hold", 64'(MinCost), 64'(em));
      check("matchcount_hold", 64'(MatchCount), 64'(ec));
      $display("[TB] search mode=%0d delay=%0d..%0d stray=%0d: MinCost=%0d MatchCount=%0d (model %0d/%0d)",
               m, dlo, dhi, inj, MinCost, MatchCount, em, ec);
    end
  endtask

  initial begin
    int em;
    int ec;
    int vbefore;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mat[i][j] = int'($urandom_range(0, 15));

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_not_busy", 64'(busy), 64'(0));

    run_search(0, 0, 0, 1'b0);
    run_search(1, 0, 2, 1'b0);
    run_search(2, 0, 3, 1'b0);
    run_search(2, 0, 3, 1'b1);

    // Abort during a long WAIT
    mode   = 2;
    dly_lo = 20;
    dly_hi = 20;
    prepare_expect(em, ec);
    vbefore = valid_cnt;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && launches < 25; cyc++) @(negedge CLK);
    check("abort_progress", 64'(launches >= 25), 64'(1));
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_reset("abort");
    exp_arr_q.delete();
    exp_res_q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_after_abort", 64'(busy), 64'(0));
    check("no_valid_after_abort", 64'(valid_cnt), 64'(vbefore));
    $display("[TB] aborted search after %0d-cycle waits, no Valid seen", dly_lo);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) mat[i][j] = int'($urandom_range(0, 7));
    run_search(2, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
